// File: rtl/store_buffer_pkg.sv
// Shared size codes and entry layout for the posted-store buffer.
package store_buffer_pkg;

  localparam logic [2:0] STORE_WORD = 3'b000;
  localparam logic [2:0] STORE_HALF = 3'b001;
  localparam logic [2:0] STORE_BYTE = 3'b010;

  localparam logic [2:0] LOAD_W  = 3'b000;
  localparam logic [2:0] LOAD_H  = 3'b001;
  localparam logic [2:0] LOAD_HU = 3'b010;
  localparam logic [2:0] LOAD_B  = 3'b011;
  localparam logic [2:0] LOAD_BU = 3'b100;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [1:0]  byte_off;
    logic [2:0]  typ;
    logic [31:0] data;
    logic [31:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_cam.sv
// DEPTH-way word-address comparator; reports a hit and the youngest
// hitting slot by scanning from the oldest entry forward.
module stbuf_cam #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]       valid,
  input  logic [DEPTH-1:0][29:0] tags,
  input  logic [PTR_W-1:0]       oldest,
  input  logic [29:0]            key,
  output logic                   hit,
  output logic [PTR_W-1:0]       idx
);

  logic [PTR_W-1:0] j;

  always_comb begin
    hit = 1'b0;
    idx = oldest;
    j   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      j = oldest + k[PTR_W-1:0];
      if (valid[j] && tags[j] == key) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO owning the DM port; optional load forwarding
// from a matching word store under STBUF_FWD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_req,
  input  logic [2:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [31:0] st_pc,
  input  logic        ld_req,
  input  logic [2:0]  ld_type,
  input  logic [31:0] ld_addr,
  input  logic [31:0] dm_rdata,
  output logic [31:0] ld_data,
  output logic        stall_M,
  output logic        dm_we,
  output logic [2:0]  dm_load,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  output logic        empty
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]       wr_ptr, rd_ptr, idx;
  logic [PTR_W:0]         count;
  logic [DEPTH-1:0]       valid;
  logic [DEPTH-1:0][29:0] tags;
  sb_entry_t              ent [DEPTH];
  sb_entry_t              head;
  logic                   cam_hit, hit, full, fwd;
  logic                   drain, push;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) tags[i] = ent[i].word_addr;
  end

  stbuf_cam #(.DEPTH(DEPTH)) u_cam (
    .valid  (valid),
    .tags   (tags),
    .oldest (rd_ptr),
    .key    (ld_addr[31:2]),
    .hit    (cam_hit),
    .idx    (idx)
  );

  assign hit  = ld_req && cam_hit;
  assign full = (count == FULL);
  assign head = ent[rd_ptr];

`ifdef STBUF_FWD_EN
  assign fwd = hit && !full && ld_type == LOAD_W
            && ent[idx].typ == STORE_WORD;
  assign ld_data = fwd ? ent[idx].data : dm_rdata;
`else
  logic unused_idx;
  assign unused_idx = ^idx;
  assign fwd     = 1'b0;
  assign ld_data = dm_rdata;
`endif

  // a forwarded hit neither stalls nor forces the entry out early
  assign drain = (count != '0)
              && (!ld_req || full || (hit && !fwd));
  assign stall_M = (st_req && full && !drain)
                || (ld_req && ((hit && !fwd) || drain));
  assign push  = st_req && !stall_M;
  assign empty = (count == '0);

  always_comb begin
    dm_we    = 1'b0;
    dm_load  = ld_type;
    dm_addr  = ld_addr;
    dm_wdata = '0;
    dm_pc    = '0;
    if (drain) begin
      dm_we    = 1'b1;
      dm_load  = head.typ;
      dm_addr  = {head.word_addr, head.byte_off};
      dm_wdata = head.data;
      dm_pc    = head.pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      // clear before set: when full, push and pop share one slot
      if (drain) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      unique case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent[wr_ptr] <= '{word_addr: st_addr[31:2],
                       byte_off:  st_addr[1:0],
                       typ:       st_type,
                       data:      st_data,
                       pc:        st_pc};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a byte-addressed DM model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk, reset;
  logic        st_req, ld_req;
  logic [2:0]  st_type, ld_type;
  logic [31:0] st_addr, st_data, st_pc, ld_addr;
  logic [31:0] dm_rdata, ld_data, dm_addr, dm_wdata, dm_pc;
  logic        stall_M, dm_we, empty;
  logic [2:0]  dm_load;

  int checks = 0;
  int errors = 0;

  store_buffer dut (
    .clk(clk), .reset(reset),
    .st_req(st_req), .st_type(st_type), .st_addr(st_addr),
    .st_data(st_data), .st_pc(st_pc),
    .ld_req(ld_req), .ld_type(ld_type), .ld_addr(ld_addr),
    .dm_rdata(dm_rdata), .ld_data(ld_data), .stall_M(stall_M),
    .dm_we(dm_we), .dm_load(dm_load), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_pc(dm_pc), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dmem [1024];
  logic [9:0] wa;
  logic [31:0] rw;
  logic [15:0] rh;
  logic [7:0]  rb;

  always @(posedge clk) begin
    if (dm_we) begin
      unique case (dm_load)
        STORE_WORD: for (int b = 0; b < 4; b++)
          dmem[{dm_addr[9:2], 2'b00} + 10'(b)] <= dm_wdata[8*b +: 8];
        STORE_HALF: begin
          dmem[{dm_addr[9:1], 1'b0}] <= dm_wdata[7:0];
          dmem[{dm_addr[9:1], 1'b1}] <= dm_wdata[15:8];
        end
        default: dmem[dm_addr[9:0]] <= dm_wdata[7:0];
      endcase
    end
  end

  always_comb begin
    wa = {dm_addr[9:2], 2'b00};
    rw = {dmem[wa+10'd3], dmem[wa+10'd2], dmem[wa+10'd1], dmem[wa]};
    rh = dm_addr[1] ? rw[31:16] : rw[15:0];
    rb = rw[8*dm_addr[1:0] +: 8];
    unique case (dm_load)
      LOAD_H:  dm_rdata = {{16{rh[15]}}, rh};
      LOAD_HU: dm_rdata = {16'h0, rh};
      LOAD_B:  dm_rdata = {{24{rb[7]}}, rb};
      LOAD_BU: dm_rdata = {24'h0, rb};
      default: dm_rdata = rw;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic [2:0] sty,
                      input logic [31:0] sa, input logic [31:0] sd,
                      input logic l, input logic [2:0] lty,
                      input logic [31:0] la);
    @(negedge clk);
    st_req  = s;
    st_type = sty;
    st_addr = sa;
    st_data = sd;
    st_pc   = 32'h4000_0000 + sa;
    ld_req  = l;
    ld_type = lty;
    ld_addr = la;
    #1;
  endtask

  task automatic nop();
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic ld(input logic [2:0] t, input logic [31:0] a);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, t, a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = 8'h00;
    reset = 1'b1;
    st_req = 0; st_type = 0; st_addr = 0; st_data = 0; st_pc = 0;
    ld_req = 0; ld_type = 0; ld_addr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(stall_M), 32'h0);
    chk("rst_we",    32'(dm_we),   32'h0);
    chk("rst_load",  32'(dm_load), 32'h0);
    chk("rst_addr",  dm_addr,      32'h0);
    chk("rst_wdata", dm_wdata,     32'h0);
    chk("rst_pc",    dm_pc,        32'h0);
    chk("rst_empty", 32'(empty),   32'h1);

    // single word store drains the next cycle
    step(1'b1, STORE_WORD, 32'h10, 32'h1234_5678, 1'b0, 3'd0, 32'h0);
    chk("sw_stall", 32'(stall_M), 32'h0);
    chk("sw_we0",   32'(dm_we),   32'h0);
    nop();
    chk("sw_we1",   32'(dm_we),   32'h1);
    chk("sw_addr",  dm_addr,      32'h10);
    chk("sw_wdata", dm_wdata,     32'h1234_5678);
    chk("sw_pc",    dm_pc,        32'h4000_0010);
    chk("sw_load",  32'(dm_load), 32'h0);
    nop();
    chk("sw_we2",   32'(dm_we),   32'h0);
    chk("sw_empty", 32'(empty),   32'h1);
    ld(LOAD_W, 32'h10);
    chk("sw_ld",    ld_data,      32'h1234_5678);

    // fill with byte stores under a non-hitting load stream
    for (int i = 0; i < 4; i++) begin
      step(1'b1, STORE_BYTE, 32'h20 + 32'(i), 32'hAA + 32'(i) * 32'h11,
           1'b1, LOAD_W, 32'h100);
      chk("fill_stall", 32'(stall_M), 32'h0);
    end
    step(1'b1, STORE_BYTE, 32'h24, 32'hEE, 1'b1, LOAD_W, 32'h100);
    chk("full_stall", 32'(stall_M), 32'h1);
    chk("full_we",    32'(dm_we),   32'h1);
    chk("full_addr",  dm_addr,      32'h20);
    chk("full_wdata", dm_wdata,     32'hAA);
    step(1'b1, STORE_BYTE, 32'h24, 32'hEE, 1'b1, LOAD_W, 32'h100);
    chk("re_stall",   32'(stall_M), 32'h0);
    chk("re_ld",      ld_data,      32'h0);
    for (int i = 0; i < 4; i++) begin
      nop();
      chk("ord_addr",  dm_addr,  32'h21 + 32'(i));
      chk("ord_wdata", dm_wdata, 32'hBB + 32'(i) * 32'h11);
    end
    nop();
    chk("ord_empty", 32'(empty), 32'h1);
    ld(LOAD_W, 32'h20);
    chk("ord_word", ld_data, 32'hDDCC_BBAA);
    ld(LOAD_B, 32'h24);
    chk("ord_lb",   ld_data, 32'hFFFF_FFEE);

    // load hitting a pending half store stalls one cycle
    step(1'b1, STORE_HALF, 32'h42, 32'hBEEF, 1'b0, 3'd0, 32'h0);
    chk("sh_stall", 32'(stall_M), 32'h0);
    ld(LOAD_HU, 32'h40);
    chk("hit_stall", 32'(stall_M), 32'h1);
    chk("hit_we",    32'(dm_we),   32'h1);
    chk("hit_addr",  dm_addr,      32'h42);
    chk("hit_load",  32'(dm_load), 32'(STORE_HALF));
    ld(LOAD_HU, 32'h40);
    chk("hit_stall2", 32'(stall_M), 32'h0);
    chk("lhu_40",     ld_data,      32'h0);
    ld(LOAD_HU, 32'h42);
    chk("lhu_42",     ld_data,      32'h0000_BEEF);
    ld(LOAD_H, 32'h42);
    chk("lh_42",      ld_data,      32'hFFFF_BEEF);

    // full buffer with simultaneous push and pop
    for (int i = 0; i < 4; i++)
      step(1'b1, STORE_WORD, 32'h200 + 32'(4 * i), 32'(i + 1),
           1'b1, LOAD_W, 32'h100);
    step(1'b1, STORE_WORD, 32'h210, 32'h5, 1'b0, 3'd0, 32'h0);
    chk("pp_stall", 32'(stall_M), 32'h0);
    chk("pp_we",    32'(dm_we),   32'h1);
    chk("pp_addr",  dm_addr,      32'h200);
    chk("pp_wdata", dm_wdata,     32'h1);
    for (int i = 0; i < 4; i++) begin
      nop();
      chk("pp_daddr", dm_addr,    32'h204 + 32'(4 * i));
      chk("pp_ddata", dm_wdata,   32'(i + 2));
    end
    nop();
    chk("pp_empty", 32'(empty), 32'h1);

    // asynchronous reset with pending entries
    for (int i = 0; i < 3; i++)
      step(1'b1, STORE_WORD, 32'h300 + 32'(4 * i), 32'h11 * 32'(i + 1),
           1'b1, LOAD_W, 32'h100);
    nop();
    chk("pre_rst_we",   32'(dm_we), 32'h1);
    chk("pre_rst_addr", dm_addr,    32'h300);
    #1 reset = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_we",    32'(dm_we), 32'h0);
    #4 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nop();
      chk("post_rst_we", 32'(dm_we), 32'h0);
    end
    ld(LOAD_W, 32'h300);
    chk("post_rst_mem", ld_data, 32'h0);

    // word store followed by a word load of the same address
    step(1'b1, STORE_WORD, 32'h80, 32'hCAFE_F00D, 1'b0, 3'd0, 32'h0);
    ld(LOAD_W, 32'h80);
`ifdef STBUF_FWD_EN
    chk("fwd_stall", 32'(stall_M), 32'h0);
    chk("fwd_we",    32'(dm_we),   32'h0);
    chk("fwd_data",  ld_data,      32'hCAFE_F00D);
    nop();
    chk("fwd_drain", 32'(dm_we),   32'h1);
    chk("fwd_addr",  dm_addr,      32'h80);
`else
    chk("lw_stall",  32'(stall_M), 32'h1);
    chk("lw_we",     32'(dm_we),   32'h1);
    ld(LOAD_W, 32'h80);
    chk("lw_stall2", 32'(stall_M), 32'h0);
    chk("lw_data",   ld_data,      32'hCAFE_F00D);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
